// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and constants for the memory-access stage
package mem_access_stage_pkg;

  localparam int XLEN = 64;
  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic            valid;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            zero;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_branch;
  } ex_mem_t;

  // Doubleword accesses must have the low three address bits clear.
  function automatic logic is_aligned(input logic [2:0] low_bits);
    return (low_bits & ALIGN_MASK) == 3'b000;
  endfunction

endpackage

// File: rtl/mem_access_stage_flopre.sv
// rtl/mem_access_stage_flopre.sv - enable flip-flop with synchronous reset
module flopre #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - LEGv8 memory-access stage: EX/MEM register, data-bus FSM, stall
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         Branch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  input  logic [N-1:0] PCBranch_E,
  output logic         stall_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ready,
  input  logic         dm_rvalid,
  input  logic [N-1:0] dm_rdata,
  output logic         valid_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] readData_M,
  output logic         PCSrc_M,
  output logic         misaligned_M
);

  ex_mem_t    ex_d;
  ex_mem_t    ex_q;
  mem_state_t state_q;
  mem_state_t state_d;
  logic       complete;
  logic       req;
  logic       stall;
  logic       e_mem_op;
  logic       m_aligned;

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = valid_E;
    ex_d.mem_read   = MemRead_E;
    ex_d.mem_write  = MemWrite_E;
    ex_d.branch     = Branch_E;
    ex_d.zero       = zero_E;
    ex_d.alu_result = XLEN'(aluResult_E);
    ex_d.write_data = XLEN'(writeData_E);
    ex_d.pc_branch  = XLEN'(PCBranch_E);
  end

  flopre #(
    .WIDTH($bits(ex_mem_t))
  ) u_ex_mem_reg (
    .clk  (clk),
    .reset(reset),
    .en   (~stall),
    .d    (ex_d),
    .q    (ex_q)
  );

  // Only feeds the state register, so no _E input reaches an output combinationally.
  assign e_mem_op  = valid_E & (MemRead_E | MemWrite_E) & is_aligned(aluResult_E[2:0]);
  assign m_aligned = is_aligned(ex_q.alu_result[2:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    req      = 1'b0;
    case (state_q)
      IDLE: complete = ex_q.valid;
      REQ: begin
        req = 1'b1;
        if (dm_ready) begin
          if (ex_q.mem_read) begin
            state_d = WAIT_R;
          end else begin
            complete = 1'b1;
          end
        end
      end
      WAIT_R: complete = dm_rvalid;
      default: state_d = IDLE;
    endcase
    stall = (state_q != IDLE) & ~complete;
    // The next instruction loads at the completion edge, so a memory op goes straight to REQ.
    if (!stall) begin
      state_d = e_mem_op ? REQ : IDLE;
    end
  end

  assign stall_M      = stall;
  assign valid_M      = complete;
  assign dm_req       = req;
  assign dm_we        = req & ex_q.mem_write & ~ex_q.mem_read;
  assign dm_addr      = req ? N'(ex_q.alu_result) : '0;
  assign dm_wdata     = req ? N'(ex_q.write_data) : '0;
  assign readData_M   = (state_q == WAIT_R && dm_rvalid) ? dm_rdata : '0;
  assign aluResult_M  = N'(ex_q.alu_result);
  assign PCBranch_M   = N'(ex_q.pc_branch);
  assign PCSrc_M      = complete & ex_q.branch & ex_q.zero;
  assign misaligned_M = complete & (ex_q.mem_read | ex_q.mem_write) & ~m_aligned;

endmodule
